nios2_jtag_ocimem_engine: RTL and testbench
===========================================

// Module: nios2_jtag_ocimem_engine
// PURPOSE
// - Consumes the decoded sysclk-domain JTAG debug commands (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
// - Turns them into single-word Avalon-MM master reads and writes to the debug/OCI memory.
// - Returns MonDReg, monitor_ready and monitor_error to the JTAG debug module, which shifts them back out through TCK.
// PARAMETERS
// - ADDR_W       8    word-address width of the OCI memory
// - TIMEOUT_CYC  255  max av_waitrequest cycles before abort (OCIMEM_TIMEOUT_EN only); legal range 1..65535
// PORTS
// - clk                      in   1       system clock; single clock domain
// - reset                    in   1       asynchronous, active-high reset
// - jdo                      in   38      JTAG data word, already synchronised to clk
// - take_action_ocimem_a     in   1       1-cycle pulse: load address; jdo[35] = also issue read
// - take_action_ocimem_b     in   1       1-cycle pulse: write jdo[34:3] at current address
// - take_no_action_ocimem_a  in   1       1-cycle pulse: streaming read at current address
// - av_address               out  ADDR_W  word address
// - av_read                  out  1       read strobe, held until accepted
// - av_write                 out  1       write strobe, held until accepted
// - av_writedata             out  32      write data
// - av_readdata              in   32      read data, valid in the cycle where av_read & !av_waitrequest
// - av_waitrequest           in   1       slave stall
// - MonDReg                  out  32      last read data, or last written data
// - monitor_ready            out  1       1 = idle, result valid
// - monitor_error            out  1       sticky: overrun or timeout
// BEHAVIOUR
// - Reset values: addr=0, MonDReg=0, monitor_ready=1, monitor_error=0, av_read=av_write=0, av_writedata=0, state=IDLE.
// - Reset asserted mid-access drops the access immediately; no retry after release.
// - States: IDLE, RD, WR.
// - IDLE + ocimem_a:
//   - addr <= jdo[17+ADDR_W-1:17].
//   - If jdo[35]=1: go to RD with no address increment afterwards.
//   - Else: stay IDLE, monitor_ready stays 1.
// - IDLE + ocimem_b: av_writedata <= jdo[34:3], MonDReg <= jdo[34:3], go to WR; addr increments on completion.
// - IDLE + no_action_ocimem_a: go to RD; addr increments on completion.
// - Command priority when pulses coincide: ocimem_b > ocimem_a > no_action_a; lower-priority pulses are discarded silently.
// - Timing on any accepted command:
//   - monitor_ready falls in the next cycle.
//   - av_read/av_write assert in that same cycle.
// - RD: av_read held while av_waitrequest=1.
//   - Completion cycle (!av_waitrequest): MonDReg <= av_readdata, then IDLE.
//   - Next cycle: av_read=0, monitor_ready=1.
// - WR: same as RD with av_write; MonDReg is not updated from the bus.
// - Minimum latency: pulse to monitor_ready=1 is 3 cycles when av_waitrequest=0.
// - addr wraps from 2^ADDR_W-1 to 0 with no error.
// - Overrun: any command pulse while state != IDLE is ignored and sets monitor_error=1.
// - monitor_error clears only on an ocimem_a pulse with jdo[36]=1. That same pulse is still decoded normally.
// - av_address = addr; it is stable for the whole access.
// CONFIGURATION
// - OCIMEM_TIMEOUT_EN defined:
//   - A wait counter counts av_waitrequest cycles in RD/WR.
//   - When the count reaches TIMEOUT_CYC: strobe deasserts, MonDReg <= 32'hDEAD_BEEF, monitor_error=1, addr unchanged, return to IDLE.
// - OCIMEM_TIMEOUT_EN undefined: no counter; the engine waits indefinitely on av_waitrequest.
// STRUCTURE
// - Package nios2_jtag_ocimem_pkg holds:
//   - the state enum;
//   - jdo field localparams (JDO_RD_BIT=35, JDO_CLRERR_BIT=36, JDO_ADDR_LSB=17, JDO_WDATA_LSB=3);
//   - TIMEOUT_PATTERN=32'hDEAD_BEEF.
// - One sub-module, nios2_jtag_ocimem_timeout: loadable down-counter with an expire pulse. It is instantiated only under OCIMEM_TIMEOUT_EN.
// TESTING
// - ocimem_a, jdo[24:17]=8'h10, jdo[35]=1, readdata=32'h1234_5678, waitrequest=0 -> av_read at addr 0x10 for 1 cycle; MonDReg=32'h1234_5678; ready=1 after 3 cycles; addr stays 0x10.
// - 3x ocimem_b with data 1,2,3 starting at addr 0xFE -> writes land at 0xFE, 0xFF, 0x00 (wrap); MonDReg=3; error=0.
// - waitrequest held for 5 cycles during no_action read -> av_read and av_address stable for 6 cycles; single capture; addr increments by 1.
// - ocimem_b pulse during an in-flight read -> write ignored, error=1; next ocimem_a with jdo[36]=1 -> error=0.
// - OCIMEM_TIMEOUT_EN with TIMEOUT_CYC=4 and waitrequest stuck at 1 -> strobe drops after 4 cycles; MonDReg=32'hDEAD_BEEF; error=1; ready=1.
// - Reset asserted mid-WR -> av_write=0 and ready=1 asynchronously; no write completes after reset release.

Source files
------------

// File: rtl/nios2_jtag_ocimem_pkg.sv
// rtl/nios2_jtag_ocimem_pkg.sv - shared types and jdo field positions for the OCI memory engine
package nios2_jtag_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    localparam int JDO_RD_BIT     = 35;
    localparam int JDO_CLRERR_BIT = 36;
    localparam int JDO_ADDR_LSB   = 17;
    localparam int JDO_WDATA_LSB  = 3;

    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/nios2_jtag_ocimem_if.sv
// rtl/nios2_jtag_ocimem_if.sv - Avalon-MM single-word master bus between the engine and OCI memory
interface nios2_jtag_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;

    modport master (
        output av_address, av_read, av_write, av_writedata,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata,
        output av_readdata, av_waitrequest
    );
endinterface

// File: rtl/nios2_jtag_ocimem_timeout.sv
// rtl/nios2_jtag_ocimem_timeout.sv - loadable down-counter that pulses expire on its last decrement
module nios2_jtag_ocimem_timeout #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign expire = dec && (cnt_q == ONE);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nios2_jtag_ocimem_engine.sv
// rtl/nios2_jtag_ocimem_engine.sv - JTAG debug command to Avalon-MM OCI memory access engine
// Optional wait-request abort is enabled by defining OCIMEM_TIMEOUT_EN.
module nios2_jtag_ocimem_engine
    import nios2_jtag_ocimem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [37:0]                 jdo,
    input  logic                        take_action_ocimem_a,
    input  logic                        take_action_ocimem_b,
    input  logic                        take_no_action_ocimem_a,
    nios2_jtag_ocimem_if.master         av,
    output logic [31:0]                 MonDReg,
    output logic                        monitor_ready,
    output logic                        monitor_error
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mon_q, mon_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              incr_q, incr_d;
    logic              tmo_expire;
    logic              done;

    wire unused_jdo = ^{jdo[37], jdo[JDO_WDATA_LSB-1:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mon_d   = mon_q;
        wdata_d = wdata_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        incr_d  = incr_q;
        done    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (take_action_ocimem_b) begin
                wdata_d = jdo[JDO_WDATA_LSB +: 32];
                mon_d   = jdo[JDO_WDATA_LSB +: 32];
                state_d = ST_WR;
                wr_d    = 1'b1;
                rdy_d   = 1'b0;
                incr_d  = 1'b1;
            end else if (take_action_ocimem_a) begin
                addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_CLRERR_BIT]) begin
                    err_d = 1'b0;
                end
                if (jdo[JDO_RD_BIT]) begin
                    state_d = ST_RD;
                    rd_d    = 1'b1;
                    rdy_d   = 1'b0;
                    incr_d  = 1'b0;
                end
            end else if (take_no_action_ocimem_a) begin
                state_d = ST_RD;
                rd_d    = 1'b1;
                rdy_d   = 1'b0;
                incr_d  = 1'b1;
            end
        end else begin
            // Commands arriving mid-access are dropped but flagged as overrun.
            if (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) begin
                err_d = 1'b1;
            end
            if (!av.av_waitrequest) begin
                if (state_q == ST_RD) begin
                    mon_d = av.av_readdata;
                end
                if (incr_q) begin
                    addr_d = addr_q + 1'b1;
                end
                done = 1'b1;
            end else if (tmo_expire) begin
                mon_d = TIMEOUT_PATTERN;
                err_d = 1'b1;
                done  = 1'b1;
            end
            if (done) begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                rdy_d   = 1'b1;
            end
        end
    end

`ifdef OCIMEM_TIMEOUT_EN
    logic tmo_load;
    logic tmo_dec;

    assign tmo_load = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    assign tmo_dec  = (state_q != ST_IDLE) && av.av_waitrequest;

    nios2_jtag_ocimem_timeout #(
        .W(16)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (tmo_load),
        .load_val (16'(TIMEOUT_CYC)),
        .dec      (tmo_dec),
        .expire   (tmo_expire)
    );
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mon_q   <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            incr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            incr_q  <= incr_d;
        end
    end

    assign av.av_address   = addr_q;
    assign av.av_read      = rd_q;
    assign av.av_write     = wr_q;
    assign av.av_writedata = wdata_q;
    assign MonDReg         = mon_q;
    assign monitor_ready   = rdy_q;
    assign monitor_error   = err_q;
endmodule

// File: tb/tb_nios2_jtag_ocimem_engine.sv
// tb/tb_nios2_jtag_ocimem_engine.sv - directed vector bench for the OCI memory engine
module tb_nios2_jtag_ocimem_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0;
    logic        ta_b = 1'b0;
    logic        tna_a = 1'b0;
    logic [31:0] mon;
    logic        ready;
    logic        error;

    int checks = 0;
    int errors = 0;

    nios2_jtag_ocimem_if #(.ADDR_W(8)) bus ();

    nios2_jtag_ocimem_engine #(
        .ADDR_W      (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .av                      (bus),
        .MonDReg                 (mon),
        .monitor_ready           (ready),
        .monitor_error           (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a, b, na;
        logic        clr, rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_rd, exp_wr;
        logic [7:0]  exp_acc_addr;
        logic [31:0] exp_mon;
        logic [7:0]  exp_next_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] mk_jdo(input logic clr, input logic rd,
                                           input logic [7:0] addr, input logic [31:0] wdata);
        logic [37:0] j;
        j = '0;
        j[34:3]  = wdata;
        j[24:17] = j[24:17] | addr;
        j[35]    = rd;
        j[36]    = clr;
        return j;
    endfunction

    // Drives one pulse across a rising edge; returns #1 after that edge.
    task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
        @(negedge clk);
        jdo = j; ta_a = a; ta_b = b; tna_a = na;
        @(posedge clk);
        #1;
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           a  b  na clr rd addr   wdata         rdata         rd wr acc    mon           next
        vecs[0] = '{1, 0, 0, 0, 1, 8'h10, 32'h0,        32'h1234_5678, 1, 0, 8'h10, 32'h1234_5678, 8'h10};
        vecs[1] = '{1, 0, 0, 0, 0, 8'hFE, 32'h0,        32'h0,        0, 0, 8'hFE, 32'h1234_5678, 8'hFE};
        vecs[2] = '{0, 1, 0, 0, 0, 8'h00, 32'h1,        32'h0,        0, 1, 8'hFE, 32'h1,        8'hFF};
        vecs[3] = '{0, 1, 0, 0, 0, 8'h00, 32'h2,        32'h0,        0, 1, 8'hFF, 32'h2,        8'h00};
        vecs[4] = '{0, 1, 0, 0, 0, 8'h00, 32'h3,        32'h0,        0, 1, 8'h00, 32'h3,        8'h01};
        vecs[5] = '{0, 0, 1, 0, 0, 8'h00, 32'h0,        32'hCAFE_F00D, 1, 0, 8'h01, 32'hCAFE_F00D, 8'h02};
        vecs[6] = '{1, 1, 1, 0, 1, 8'h00, 32'hA5A5_0000, 32'h0,       0, 1, 8'h02, 32'hA5A5_0000, 8'h03};
        vecs[7] = '{1, 0, 1, 0, 1, 8'h40, 32'h0,        32'h0BAD_F00D, 1, 0, 8'h40, 32'h0BAD_F00D, 8'h40};

        bus.av_readdata    = '0;
        bus.av_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mon", mon, 32'h0);
        chk("rst_read", 32'(bus.av_read), 32'd0);
        chk("rst_write", 32'(bus.av_write), 32'd0);
        chk("rst_addr", 32'(bus.av_address), 32'h0);
        chk("rst_wdata", bus.av_writedata, 32'h0);

        for (int i = 0; i < 8; i++) begin
            bus.av_readdata = vecs[i].rdata;
            pulse(vecs[i].a, vecs[i].b, vecs[i].na,
                  mk_jdo(vecs[i].clr, vecs[i].rd, vecs[i].addr, vecs[i].wdata));
            if (vecs[i].exp_rd || vecs[i].exp_wr) begin
                chk($sformatf("v%0d_busy_ready", i), 32'(ready), 32'd0);
                chk($sformatf("v%0d_read", i), 32'(bus.av_read), 32'(vecs[i].exp_rd));
                chk($sformatf("v%0d_write", i), 32'(bus.av_write), 32'(vecs[i].exp_wr));
                chk($sformatf("v%0d_acc_addr", i), 32'(bus.av_address), 32'(vecs[i].exp_acc_addr));
                if (vecs[i].exp_wr)
                    chk($sformatf("v%0d_wdata", i), bus.av_writedata, vecs[i].wdata);
                step();
            end
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
            chk($sformatf("v%0d_strobes", i), 32'({bus.av_read, bus.av_write}), 32'd0);
            chk($sformatf("v%0d_mon", i), mon, vecs[i].exp_mon);
            chk($sformatf("v%0d_next_addr", i), 32'(bus.av_address), 32'(vecs[i].exp_next_addr));
            chk($sformatf("v%0d_error", i), 32'(error), 32'd0);
        end

        // Streaming read stalled for 5 cycles: strobe and address held, one capture.
        bus.av_waitrequest = 1'b1;
        bus.av_readdata = 32'h0000_1000;
        pulse(1'b0, 1'b0, 1'b1, '0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("wait_read_c%0d", c), 32'(bus.av_read), 32'd1);
            chk($sformatf("wait_addr_c%0d", c), 32'(bus.av_address), 32'h40);
            chk($sformatf("wait_ready_c%0d", c), 32'(ready), 32'd0);
            if (c == 5) bus.av_waitrequest = 1'b0;
            bus.av_readdata = 32'h0000_1001 + 32'(c);
            if (c < 5) step();
        end
        step();
        chk("wait_done_ready", 32'(ready), 32'd1);
        chk("wait_done_read", 32'(bus.av_read), 32'd0);
        chk("wait_capture", mon, 32'h0000_1006);
        chk("wait_addr_inc", 32'(bus.av_address), 32'h41);

        // Write pulse during an in-flight read is an overrun.
        bus.av_waitrequest = 1'b1;
        bus.av_readdata = 32'hBEEF_0001;
        pulse(1'b0, 1'b0, 1'b1, '0);
        pulse(1'b0, 1'b1, 1'b0, mk_jdo(1'b0, 1'b0, 8'h00, 32'h77));
        chk("ovr_no_write", 32'(bus.av_write), 32'd0);
        chk("ovr_error_set", 32'(error), 32'd1);
        bus.av_waitrequest = 1'b0;
        step();
        chk("ovr_ready", 32'(ready), 32'd1);
        chk("ovr_mon", mon, 32'hBEEF_0001);
        chk("ovr_addr", 32'(bus.av_address), 32'h42);
        chk("ovr_error_held", 32'(error), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, mk_jdo(1'b1, 1'b0, 8'h80, 32'h0));
        chk("clr_error", 32'(error), 32'd0);
        chk("clr_addr", 32'(bus.av_address), 32'h80);
        chk("clr_ready", 32'(ready), 32'd1);

`ifdef OCIMEM_TIMEOUT_EN
        // Stuck slave: four strobe cycles, then abort.
        bus.av_waitrequest = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, '0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("tmo_read_c%0d", c), 32'(bus.av_read), 32'd1);
            step();
        end
        chk("tmo_read_drop", 32'(bus.av_read), 32'd0);
        chk("tmo_ready", 32'(ready), 32'd1);
        chk("tmo_mon", mon, 32'hDEAD_BEEF);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_addr", 32'(bus.av_address), 32'h80);
        bus.av_waitrequest = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, mk_jdo(1'b1, 1'b0, 8'h80, 32'h0));
        chk("tmo_clr", 32'(error), 32'd0);
`endif

        // Reset mid-write drops the access without a clock edge.
        bus.av_waitrequest = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, mk_jdo(1'b0, 1'b0, 8'h00, 32'h55));
        chk("rstwr_write", 32'(bus.av_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstwr_write_drop", 32'(bus.av_write), 32'd0);
        chk("rstwr_ready", 32'(ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.av_waitrequest = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rstwr_idle_write_c%0d", c), 32'(bus.av_write), 32'd0);
        end
        chk("rstwr_addr", 32'(bus.av_address), 32'h0);
        chk("rstwr_mon", mon, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
